tile_fetch_ctrl: RTL and testbench

TILE_FETCH_CTRL -- requirements
Module: tile_fetch_ctrl

---
 rtl/acc_pkg.sv | 14 +
 rtl/stream_fifo2.sv | 49 ++++
 rtl/tile_fetch_ctrl.sv | 156 +++++++++++++++
 tb/tb_tile_fetch_ctrl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/acc_pkg.sv
// Shared types for the accelerator tile fetch path: controller states and
// the output FIFO capacity that drives the read credit check.
package acc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } fetch_state_e;

  localparam int unsigned FifoDepth = 2;

endpackage

// File: rtl/stream_fifo2.sv
// Two-entry FIFO buffering RAM read data (plus row/tile flags) ahead of the
// output stream; the head entry stays stable until it is popped.
module stream_fifo2 #(
  parameter int unsigned WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  output logic [1:0]       o_count
);

  logic [WIDTH-1:0] r_mem [2];
  logic             r_wptr;
  logic             r_rptr;
  logic [1:0]       r_count;
  logic             w_pop;

  assign w_pop = i_pop && (r_count != 2'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
      r_count <= 2'd0;
    end else begin
      if (i_push) r_wptr <= ~r_wptr;
      if (w_pop)  r_rptr <= ~r_rptr;
      case ({i_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is data-only and needs no reset; validity lives in r_count.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wptr] <= i_data;
  end

  assign o_valid = (r_count != 2'd0);
  assign o_data  = r_mem[r_rptr];
  assign o_count = r_count;

endmodule

// File: rtl/tile_fetch_ctrl.sv
// Walks a rows x cols tile of the buffer RAM in row-major order with a row
// stride, streaming each word out with end-of-row and end-of-tile flags.
module tile_fetch_ctrl
  import acc_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 1024,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int DIM_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] cfg_base,
  input  logic [DIM_WIDTH-1:0]  cfg_rows,
  input  logic [DIM_WIDTH-1:0]  cfg_cols,
  input  logic [ADDR_WIDTH-1:0] cfg_stride,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] mem_addr_b,
  input  logic [WIDTH-1:0]      mem_dout_b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_eor,
  output logic                  out_last
);

  localparam logic [DIM_WIDTH-1:0]  DimOne  = DIM_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] AddrOne = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]   DepthW  = (ADDR_WIDTH + 1)'(DEPTH);

  fetch_state_e r_state, w_state_next;

  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH-1:0] r_row_base;
  logic [ADDR_WIDTH-1:0] r_stride;
  logic [DIM_WIDTH-1:0]  r_rows;
  logic [DIM_WIDTH-1:0]  r_cols;
  logic [DIM_WIDTH-1:0]  r_row;
  logic [DIM_WIDTH-1:0]  r_col;
  logic                  r_if_valid;
  logic                  r_if_eor;
  logic                  r_if_last;

  logic                  w_accept;
  logic                  w_empty_tile;
  logic                  w_pop;
  logic                  w_issue;
  logic                  w_last_col;
  logic                  w_last_row;
  logic [2:0]            w_credit;
  logic [1:0]            w_fifo_count;
  logic                  w_fifo_valid;
  logic [WIDTH+1:0]      w_head;
  logic [ADDR_WIDTH-1:0] w_next_row_base;

  // Modular add for operands below DEPTH; avoids relying on a power-of-two DEPTH.
  function automatic logic [ADDR_WIDTH-1:0] wrap_add(input logic [ADDR_WIDTH-1:0] a,
                                                     input logic [ADDR_WIDTH-1:0] b);
    logic [ADDR_WIDTH:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= DepthW) s = s - DepthW;
    return s[ADDR_WIDTH-1:0];
  endfunction

  assign w_accept        = (r_state == IDLE) && start;
  assign w_empty_tile    = (cfg_rows == '0) || (cfg_cols == '0);
  assign w_pop           = w_fifo_valid && out_ready;
  assign w_last_col      = (r_col == (r_cols - DimOne));
  assign w_last_row      = (r_row == (r_rows - DimOne));
  assign w_next_row_base = wrap_add(r_row_base, r_stride);

  // Count the word already in flight and credit back a pop happening this cycle.
  assign w_credit = {1'b0, w_fifo_count} + {2'b0, r_if_valid} - {2'b0, w_pop};
  assign w_issue  = (r_state == FETCH) && (w_credit < 3'(FifoDepth));

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (start) w_state_next = w_empty_tile ? DONE : FETCH;
      end
      FETCH: begin
        if (w_issue && w_last_col && w_last_row) w_state_next = DRAIN;
      end
      DRAIN: begin
        if (w_pop && out_last) w_state_next = DONE;
      end
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_addr     <= '0;
      r_row_base <= '0;
      r_stride   <= '0;
      r_rows     <= '0;
      r_cols     <= '0;
      r_row      <= '0;
      r_col      <= '0;
      r_if_valid <= 1'b0;
      r_if_eor   <= 1'b0;
      r_if_last  <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_if_valid <= w_issue;
      r_if_eor   <= w_issue && w_last_col;
      r_if_last  <= w_issue && w_last_col && w_last_row;
      if (w_accept) begin
        r_rows     <= cfg_rows;
        r_cols     <= cfg_cols;
        r_stride   <= cfg_stride;
        r_row_base <= cfg_base;
        r_row      <= '0;
        r_col      <= '0;
        if (!w_empty_tile) r_addr <= cfg_base;
      end else if (w_issue) begin
        if (w_last_col) begin
          r_col      <= '0;
          r_row      <= r_row + DimOne;
          r_row_base <= w_next_row_base;
          r_addr     <= w_next_row_base;
        end else begin
          r_col  <= r_col + DimOne;
          r_addr <= wrap_add(r_addr, AddrOne);
        end
      end
    end
  end

  stream_fifo2 #(
    .WIDTH (WIDTH + 2)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (r_if_valid),
    .i_data  ({r_if_last, r_if_eor, mem_dout_b}),
    .i_pop   (w_pop),
    .o_valid (w_fifo_valid),
    .o_data  (w_head),
    .o_count (w_fifo_count)
  );

  assign busy       = (r_state != IDLE);
  assign done       = (r_state == DONE);
  assign mem_addr_b = r_addr;
  assign out_valid  = w_fifo_valid;
  assign out_data   = w_head[WIDTH-1:0];
  assign out_eor    = w_fifo_valid && w_head[WIDTH];
  assign out_last   = w_fifo_valid && w_head[WIDTH+1];

endmodule

// File: tb/tb_tile_fetch_ctrl.sv
// Bench for tile_fetch_ctrl: directed and random tiles checked against a
// row-major address/data model built from plain arithmetic.
module tb_tile_fetch_ctrl;

  localparam int WIDTH = 8;
  localparam int DEPTH = 1024;
  localparam int AW    = 10;
  localparam int DW    = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [AW-1:0]    cfg_base;
  logic [DW-1:0]    cfg_rows;
  logic [DW-1:0]    cfg_cols;
  logic [AW-1:0]    cfg_stride;
  logic             busy;
  logic             done;
  logic [AW-1:0]    mem_addr_b;
  logic [WIDTH-1:0] mem_dout_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_eor;
  logic             out_last;

  logic [WIDTH-1:0] ram [DEPTH];
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  always @(posedge clk) mem_dout_b <= ram[mem_addr_b];

  tile_fetch_ctrl #(
    .WIDTH      (WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (AW),
    .DIM_WIDTH  (DW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .cfg_base   (cfg_base),
    .cfg_rows   (cfg_rows),
    .cfg_cols   (cfg_cols),
    .cfg_stride (cfg_stride),
    .busy       (busy),
    .done       (done),
    .mem_addr_b (mem_addr_b),
    .mem_dout_b (mem_dout_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_eor    (out_eor),
    .out_last   (out_last)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Runs one tile. abort_beat >= 0 resets the DUT once that many beats have
  // handshaken; poke_busy re-pulses start with a different config mid-tile.
  task automatic run_tile(input string tag, input int base, input int rows, input int cols,
                          input int stride, input int ready_pct, input int abort_beat,
                          input bit poke_busy);
    logic [WIDTH+1:0] exp_q[$];
    int               exp_addr[$];
    int               n;
    int               a;
    int               beats;
    int               first_valid;
    int               last_beat_cyc;
    int               done_cyc;
    bit               saw_valid;
    bit               prev_stall;
    logic [WIDTH+1:0] prev_word;
    logic [WIDTH+1:0] want;
    logic [AW-1:0]    addr_before;
    bit               l;
    bit               e;
    n             = rows * cols;
    beats         = 0;
    first_valid   = -1;
    last_beat_cyc = -1;
    done_cyc      = -1;
    saw_valid     = 1'b0;
    prev_stall    = 1'b0;
    prev_word     = '0;
    for (int r = 0; r < rows; r++) begin
      for (int c = 0; c < cols; c++) begin
        a = (base + r * stride + c) % DEPTH;
        e = (c == cols - 1);
        l = e && (r == rows - 1);
        exp_addr.push_back(a);
        exp_q.push_back({l, e, ram[a]});
      end
    end
    addr_before = mem_addr_b;
    check({tag, " idle_busy"}, busy, 0);

    cfg_base   = AW'(base);
    cfg_rows   = DW'(rows);
    cfg_cols   = DW'(cols);
    cfg_stride = AW'(stride);
    start      = 1'b1;
    out_ready  = 1'b0;
    step();

    for (int cyc = 1; cyc < 500; cyc++) begin
      start      = 1'b0;
      cfg_base   = AW'($urandom);
      cfg_rows   = DW'($urandom_range(0, 9));
      cfg_cols   = DW'($urandom_range(0, 9));
      cfg_stride = AW'($urandom);
      out_ready  = ($urandom_range(0, 99) < ready_pct);
      if (cyc == 1) check({tag, " busy_c1"}, busy, 1);
      if (ready_pct == 100 && cyc <= n)
        check($sformatf("%s addr%0d", tag, cyc - 1), mem_addr_b, exp_addr[cyc-1]);
      if (n == 0 && cyc == 1) check({tag, " addr_held"}, mem_addr_b, addr_before);
      if (prev_stall)
        check({tag, " stall_hold"}, {out_valid, out_last, out_eor, out_data},
              {1'b1, prev_word});
      if (out_valid) begin
        saw_valid = 1'b1;
        if (first_valid < 0) first_valid = cyc;
      end
      if (out_valid && out_ready) begin
        beats++;
        last_beat_cyc = cyc;
        if (exp_q.size() == 0) begin
          check({tag, " beat_overflow"}, beats, n);
        end else begin
          want = exp_q.pop_front();
          check($sformatf("%s beat%0d", tag, beats), {out_last, out_eor, out_data}, want);
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_word  = {out_last, out_eor, out_data};
      if (done) begin
        done_cyc = cyc;
        break;
      end
      if (abort_beat >= 0 && beats == abort_beat) begin
        rst = 1'b1;
        step();
        rst = 1'b0;
        check({tag, " abort_busy"}, busy, 0);
        check({tag, " abort_valid"}, out_valid, 0);
        check({tag, " abort_done"}, done, 0);
        return;
      end
      if (poke_busy && cyc == 4) begin
        start    = 1'b1;
        cfg_rows = 8'd1;
        cfg_cols = 8'd1;
      end
      step();
    end

    check({tag, " done_seen"}, (done_cyc >= 0), 1);
    check({tag, " beats"}, beats, n);
    if (done_cyc >= 0) begin
      check({tag, " done_cyc"}, done_cyc, (n == 0) ? 1 : last_beat_cyc + 1);
      out_ready = 1'b0;
      step();
      check({tag, " done_pulse"}, done, 0);
      check({tag, " idle_after"}, busy, 0);
    end
    if (n == 0) check({tag, " no_valid"}, saw_valid, 0);
    if (ready_pct == 100 && n > 0) begin
      check({tag, " first_valid"}, first_valid, 3);
      check({tag, " full_rate"}, last_beat_cyc, 2 + n);
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) ram[i] = WIDTH'(i);
    rst        = 1'b1;
    start      = 1'b0;
    cfg_base   = '0;
    cfg_rows   = '0;
    cfg_cols   = '0;
    cfg_stride = '0;
    out_ready  = 1'b0;
    repeat (3) step();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_valid", out_valid, 0);
    check("rst_eor", out_eor, 0);
    check("rst_last", out_last, 0);
    check("rst_addr", mem_addr_b, 0);
    rst = 1'b0;
    step();

    run_tile("basic", 'h010, 2, 3, 8, 100, -1, 1'b0);
    run_tile("wrap", 'h3FE, 1, 4, 0, 100, -1, 1'b0);
    run_tile("zero_rows", 'h055, 0, 5, 1, 100, -1, 1'b0);
    run_tile("stall", 'h100, 4, 4, 16, 30, -1, 1'b0);
    run_tile("abort", 'h200, 4, 4, 5, 100, 5, 1'b0);
    run_tile("after_abort", 'h300, 1, 2, 3, 100, -1, 1'b0);
    run_tile("busy_start", 'h040, 3, 3, 10, 60, -1, 1'b1);
    for (int k = 0; k < 6; k++) begin
      run_tile($sformatf("rand%0d", k), int'($urandom_range(0, DEPTH - 1)),
               int'($urandom_range(1, 4)), int'($urandom_range(1, 5)),
               int'($urandom_range(0, DEPTH - 1)), (k % 2 == 0) ? 50 : 100, -1, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
